cnt_tc_log: RTL and testbench



---
 rtl/cnt_tc_log.sv | 118 +++++++++++
 tb/tb_cnt_tc_log.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cnt_tc_log.sv
// Terminal-count event logger: timestamps rising edges of tc_i into a FIFO drained over OBI.
// Optional macro CNT_TC_LOG_OVF_IRQ_EN folds the sticky overflow flag into irq_o.
package cnt_tc_log_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } sbr_obi_rsp_t;
endpackage

module cnt_tc_log
  import cnt_tc_log_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TSW   = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tc_i,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output logic         irq_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [TSW-1:0] ts_q;
  logic [TSW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt_q;
  logic           tc_q, en_q, ovf_q, rvalid_q, irq_q;
  logic [31:0]    rdata_q, rd_mux;

  logic       acc, rd, wr_ok, evt, full, empty, pop, clr, push, ovf_set;
  logic [1:0] sel;

  assign acc   = obi_req_i.req & ~rst_i;
  assign sel   = obi_req_i.addr[3:2];
  assign rd    = acc & ~obi_req_i.we;
  assign wr_ok = acc & obi_req_i.we & (obi_req_i.be == 4'b1111);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign evt   = tc_i & ~tc_q & en_q;
  assign pop   = rd & (sel == 2'd0) & ~empty;
  assign clr   = wr_ok & (sel == 2'd2) & obi_req_i.wdata[1];
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
  assign push    = evt & ~clr & (~full | pop);
  assign ovf_set = evt & ~clr & full & ~pop;

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr]);
      2'd1: rd_mux = {ovf_q, 23'd0, 8'(cnt_q)};
      2'd2: rd_mux = {31'd0, en_q};
      2'd3: rd_mux = 32'(ts_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= ts_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q     <= '0;
      tc_q     <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ts_q     <= ts_q + TSW'(1);
      tc_q     <= tc_i;
      rvalid_q <= acc;
      rdata_q  <= rd ? rd_mux : 32'd0;
`ifdef CNT_TC_LOG_OVF_IRQ_EN
      irq_q    <= ~empty | ovf_q;
`else
      irq_q    <= ~empty;
`endif
      if (wr_ok && sel == 2'd2) en_q <= obi_req_i.wdata[0];
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        if (ovf_set) ovf_q <= 1'b1;
      end
    end
  end

  assign obi_rsp_o.gnt    = acc;
  assign obi_rsp_o.rvalid = rvalid_q;
  assign obi_rsp_o.rdata  = rdata_q;
  assign irq_o            = irq_q;

  logic unused_ok;
  assign unused_ok = ^{obi_req_i.addr[31:4], obi_req_i.addr[1:0], obi_req_i.wdata[31:2]};
endmodule

// File: tb/tb_cnt_tc_log.sv
// Directed bench for cnt_tc_log (DEPTH=4, TSW=32); expected irq after overflow follows CNT_TC_LOG_OVF_IRQ_EN.
module tb_cnt_tc_log;
  import cnt_tc_log_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tc  = 1'b0;
  sbr_obi_req_t req = '0;
  sbr_obi_rsp_t rsp;
  logic         irq;
  logic [31:0]  tb_ts = '0;
  int           n_chk = 0;
  int           n_fail = 0;

  cnt_tc_log #(.DEPTH(4), .TSW(32)) dut (
    .clk_i(clk), .rst_i(rst), .tc_i(tc),
    .obi_req_i(req), .obi_rsp_o(rsp), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // reference cycle timestamp
  always @(posedge clk) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic obi(input logic we, input logic [3:0] be, input logic [3:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    req.req = 1'b1; req.we = we; req.be = be; req.addr = {28'd0, addr}; req.wdata = wdata;
    #1;
    chk("gnt", rsp.gnt, 1);
    @(posedge clk); #1;
    req = '0;
    chk("rvalid", rsp.rvalid, 1);
    rdata = rsp.rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    obi(1'b0, 4'b0000, addr, 32'd0, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] d;
    obi(1'b1, be, addr, wdata, d);
    chk("wr_rdata", d, 0);
  endtask

  task automatic pulse(output logic [31:0] ts);
    ts = tb_ts;
    tc = 1'b1; tick(); tc = 1'b0; tick();
  endtask

  task automatic wait_ts(input logic [31:0] target);
    int n = 0;
    while (tb_ts != target && n < 500) begin tick(); n++; end
    if (tb_ts != target) chk("wait_ts_timeout", tb_ts, target);
  endtask

  logic [31:0] ts [8];
  logic [31:0] d;

  initial begin
    // reset
    repeat (3) tick();
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", rsp.rvalid, 0);
    chk("rst_rdata", rsp.rdata, 0);
    rst = 1'b0;
    rd_chk("status0", 4'h4, 32'h0);
    rd_chk("data_empty", 4'h0, 32'h0);
    tick();
    chk("rvalid_drop", rsp.rvalid, 0);
    chk("irq0", irq, 0);

    // two events at known timestamps
    wr(4'h8, 32'h1, 4'hF);
    wait_ts(32'h20);
    tc = 1'b1; tick(); tc = 1'b0;
    chk("cnt_t1", 32'(dut.cnt_q), 1);
    chk("irq_t1", irq, 0);
    tick();
    chk("irq_t2", irq, 1);
    wait_ts(32'h35);
    tc = 1'b1; tick(); tc = 1'b0; tick();
    rd_chk("status2", 4'h4, 32'h2);
    chk("irq2", irq, 1);
    rd_chk("data_20", 4'h0, 32'h20);
    rd_chk("data_35", 4'h0, 32'h35);
    tick(); tick();
    chk("irq_fall", irq, 0);

    // held tc logs once
    ts[0] = tb_ts;
    tc = 1'b1; repeat (10) tick(); tc = 1'b0; tick();
    rd_chk("status_hold", 4'h4, 32'h1);
    rd_chk("data_hold", 4'h0, ts[0]);
    rd_chk("status_hold_e", 4'h4, 32'h0);

    // overflow: 6 events, 4 kept
    for (int i = 0; i < 6; i++) pulse(ts[i]);
    rd_chk("status_ovf", 4'h4, 32'h8000_0004);
    for (int i = 0; i < 4; i++) rd_chk("data_ovf", 4'h0, ts[i]);
    tick(); tick();
`ifdef CNT_TC_LOG_OVF_IRQ_EN
    chk("irq_ovf", irq, 1);
`else
    chk("irq_ovf", irq, 0);
`endif
    wr(4'h8, 32'h3, 4'hF);
    rd_chk("status_clr", 4'h4, 32'h0);
    tick(); tick();
    chk("irq_clr", irq, 0);

    // full FIFO, pop and event in same cycle
    for (int i = 0; i < 4; i++) pulse(ts[i]);
    ts[4] = tb_ts;
    tc = 1'b1;
    obi(1'b0, 4'h0, 4'h0, 32'd0, d);
    tc = 1'b0;
    chk("data_full_pop", d, ts[0]);
    rd_chk("status_full_pop", 4'h4, 32'h4);
    for (int i = 1; i < 5; i++) rd_chk("data_drain", 4'h0, ts[i]);

    // clear in same cycle as event
    pulse(ts[0]);
    rd_chk("status_pre_clr", 4'h4, 32'h1);
    tc = 1'b1;
    wr(4'h8, 32'h3, 4'hF);
    tc = 1'b0;
    rd_chk("status_clr_evt", 4'h4, 32'h0);
    rd_chk("ctrl_en", 4'h8, 32'h1);

    // partial byte-enable write ignored
    pulse(ts[0]);
    wr(4'h8, 32'h2, 4'b0011);
    rd_chk("status_be", 4'h4, 32'h1);
    rd_chk("ctrl_be", 4'h8, 32'h1);

    // disabled: no logging; TSNOW
    wr(4'h8, 32'h0, 4'hF);
    pulse(ts[1]);
    rd_chk("status_dis", 4'h4, 32'h1);
    ts[2] = tb_ts;
    rd_chk("tsnow", 4'hC, ts[2]);
    chk("irq_pre_rst", irq, 1);

    // reset during a pending read
    req.req = 1'b1; req.we = 1'b0; req.be = 4'h0; req.addr = 32'h0;
    rst = 1'b1;
    tick();
    req = '0;
    chk("rst_pend_rvalid", rsp.rvalid, 0);
    chk("rst_pend_rdata", rsp.rdata, 0);
    chk("rst_pend_irq", irq, 0);
    rst = 1'b0;
    rd_chk("status_rst", 4'h4, 32'h0);
    rd_chk("ctrl_rst", 4'h8, 32'h0);
    rd_chk("data_rst", 4'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
